hilo_divu_unit: RTL and testbench

- Multicycle unsigned divider and HI/LO register pair for the pipeline EX stage.
- Executes the divu operation that the control decoder issues (divu: RegWrite=0, ALUOp=10).
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Raises a stall to the hazard logic while a read would see an unfinished result.

---
 rtl/mips_pkg.sv | 18 +
 rtl/divu_step.sv | 20 ++
 rtl/hilo_divu_unit.sv | 94 +++++++++
 tb/tb_hilo_divu_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared decoder constants, ALUOp encoding and HI/LO divider state encoding.
package mips_pkg;
    localparam logic [5:0] R_FORMAT = 6'd0;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10
    } alu_op_t;
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;
endpackage

// File: rtl/divu_step.sv
// divu_step: one restoring-division iteration, shift {rem,quo} left and conditionally subtract.
module divu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;
    // One extra bit keeps the shifted-out MSB so the compare never loses it.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign ge       = shifted >= {1'b0, divisor};
    assign rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/hilo_divu_unit.sv
// hilo_divu_unit: multicycle unsigned divider with HI/LO registers and EX-stage stall.
// Define HILO_EARLY_TERM_EN to finish dividend<divisor cases in the start cycle.
module hilo_divu_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             mf_req,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             div_by_zero
);
    div_state_t       state;
    logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n;
    logic [CNT_W-1:0] cnt;
    logic             zero, early;

    divu_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    assign zero  = divisor == '0;
    assign stall = mf_req & busy;
`ifdef HILO_EARLY_TERM_EN
    assign early = !zero && (dividend < divisor);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // A new divu always wins, aborting any division in flight.
                div_by_zero <= zero;
                if (zero || early) begin
                    hi    <= dividend;
                    lo    <= zero ? '1 : '0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    rem   <= '0;
                    quo   <= dividend;
                    dvs   <= divisor;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
            end else if (state == RUN) begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt + 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    hi    <= rem_n;
                    lo    <= quo_n;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end else begin
                if (mt_hi) hi <= mt_data;
                if (mt_lo) lo <= mt_data;
            end
        end
    end
endmodule

// File: tb/tb_hilo_divu_unit.sv
// tb_hilo_divu_unit: vector table, directed corner sequences and random divides against a model.
module tb_hilo_divu_unit;
    localparam int W = 32;
`ifdef HILO_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, start, mf_req, mt_hi, mt_lo;
    logic [W-1:0]  dividend, divisor, mt_data, hi, lo;
    logic          busy, done, stall, div_by_zero;
    int            checks = 0, errors = 0, done_cnt = 0;

    hilo_divu_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .mf_req(mf_req), .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0 || (EARLY && a < b)) ? 0 : W;
    endfunction

    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eh, input logic [W-1:0] el, input logic edbz);
        int n;
        start_div(a, b);
        wait_done(n);
        check({name, " latency"}, 64'(n), 64'(exp_lat(a, b)));
        check({name, " hi"}, 64'(hi), 64'(eh));
        check({name, " lo"}, 64'(lo), 64'(el));
        check({name, " dbz"}, 64'(div_by_zero), 64'(edbz));
        @(posedge clk);
        #1 check({name, " done pulse width"}, 64'(done), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int n;
        logic [W-1:0] a, b;
        vecs[0] = '{32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        vecs[1] = '{32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1};
        vecs[2] = '{32'd9, 32'd3, 32'd0, 32'd3, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0};
        vecs[4] = '{32'd3, 32'd8, 32'd3, 32'd0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0};
        vecs[6] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 1'b0};

        rst_n = 1'b0; start = 1'b0; mf_req = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
        dividend = '0; divisor = '0; mt_data = '0;
        #2 check("reset state", {hi, lo}, 64'd0);
        check("reset flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 100/7 with mf_req held: stall tracks busy, released in the done cycle.
        mf_req = 1'b1;
        start_div(32'd100, 32'd7);
        for (int i = 0; i < W; i++) begin
            check($sformatf("stall busy cyc%0d", i), {62'd0, busy, stall}, 64'd3);
            @(posedge clk);
            #1;
        end
        check("100/7 done", 64'(done), 64'd1);
        check("100/7 no stall in done", 64'(stall), 64'd0);
        check("100/7 result", {hi, lo}, {32'd2, 32'd14});
        mf_req = 1'b0;
        @(posedge clk);
        #1 check("100/7 done one pulse", 64'(done), 64'd0);

        foreach (vecs[i])
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);

        // Restart mid-run: only the second division completes.
        done_cnt = 0;
        start_div(32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #1 start_div(32'hFFFF_FFFF, 32'h10);
        wait_done(n);
        check("restart latency", 64'(n), 64'(W));
        check("restart result", {hi, lo}, {32'hF, 32'h0FFF_FFFF});
        repeat (3) @(posedge clk);
        #1 check("restart done count", 64'(done_cnt), 64'd1);

        mt_hi = 1'b1; mt_data = 32'hAAAA;
        @(posedge clk);
        #1 mt_hi = 1'b0; mt_lo = 1'b1; mt_data = 32'h5555;
        @(posedge clk);
        #1 mt_lo = 1'b0;
        check("mthi/mtlo idle", {hi, lo}, {32'hAAAA, 32'h5555});

        start_div(32'd50, 32'd7);
        repeat (3) @(posedge clk);
        #1 check("hilo held in run", {hi, lo}, {32'hAAAA, 32'h5555});
        mt_hi = 1'b1; mt_data = 32'hDEAD;
        @(posedge clk);
        #1 mt_hi = 1'b0;
        wait_done(n);
        check("mthi in run dropped", {hi, lo}, {32'd1, 32'd7});

        mt_hi = 1'b1; mt_data = 32'hBEEF;
        start_div(32'd20, 32'd6);
        mt_hi = 1'b0;
        wait_done(n);
        check("start beats mthi", {hi, lo}, {32'd2, 32'd3});

        // Async reset mid-division, between clock edges.
        start_div(32'd50, 32'd5);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async reset hilo", {hi, lo}, 64'd0);
        check("async reset busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) @(posedge clk);
        #1 check("no done after reset", 64'(done_cnt), 64'd0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : (i % 4 == 1) ? 32'($urandom) >> $urandom_range(0, 31) : 32'($urandom);
            if (b == 0) run_div($sformatf("rnd%0d", i), a, b, a, '1, 1'b1);
            else run_div($sformatf("rnd%0d", i), a, b, a % b, a / b, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
